cla_pipe_adder: RTL and testbench
=================================

// Module: cla_pipe_adder
// PURPOSE
//  Parametrised, segment-pipelined carry-lookahead adder for the butterfly datapath (BFFTP).
//  Splits a WIDTH-bit add into NSEG=WIDTH/SEG segments, one segment per pipeline stage.
//  Inside each segment: 4-bit lookahead groups with per-bit g=a&b, p=a^b.
//  The registered carry ripples between stages. Throughput is one add per clock.
//  Adds valid tracking, stall and flush.
// PARAMETERS
//  WIDTH  64  operand/sum width; must be a multiple of SEG
//  SEG    16  bits per pipeline segment; must be a multiple of 4; NSEG=WIDTH/SEG >= 1
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  en         in   1      pipeline advance; 0 = all stages hold
//  flush      in   1      synchronous clear of all stage valid bits
//  in_valid   in   1      operands valid this cycle
//  a_in       in   WIDTH  operand A
//  b_in       in   WIDTH  operand B
//  c_in       in   1      carry-in to bit 0
//  sum_out    out  WIDTH  registered sum, aligned, all segments from the same operation
//  c_out      out  1      carry out of bit WIDTH-1
//  out_valid  out  1      sum_out/c_out valid; one cycle per accepted operation
// BEHAVIOUR
//  - Reset: every stage valid=0; all data and carry registers=0; sum_out=0, c_out=0, out_valid=0.
//    Reset takes effect immediately, mid-operation included; in-flight ops are discarded.
//  - Accept: an op is accepted on a rising edge with en=1, in_valid=1, flush=0.
//  - Stage 0 (accept edge): adds segment 0 with c_in and registers its sum and carry.
//    It also captures the upper operand segments.
//  - Stage s (1..NSEG-1): adds segment s using stage s-1's registered carry.
//    Earlier sum segments are delayed to stay aligned with the op.
//  - Latency: out_valid rises NSEG edges after accept, counting en=1 edges only.
//    The accept edge counts as edge 1.
//  - Carry within a segment: 4-bit groups.
//    Group carries: c[i+1] = g[i] | (p[i] & c[i]), expanded in full lookahead form.
//    Sum bit = p ^ carry-in.
//  - c_out = carry out of the final segment, registered with the final sum segment.
//  - en=0: all data, carry and valid registers hold; out_valid and sum_out hold their value.
//  - flush=1: all valid bits cleared on the edge, regardless of en.
//    An in_valid op in the same cycle is dropped. Data registers are don't-care.
//  - Back-to-back: ops on consecutive en cycles emerge on consecutive cycles, in order.
//  - Arithmetic is modulo 2^WIDTH; the overflow is visible only on c_out.
//  - NSEG=1 degenerates to a single registered CLA stage with latency 1.
// CONFIGURATION
//  CLA_PIPE_SUB_EN defined:
//    - Adds input port sub_in (1 bit), sampled with in_valid and carried in a valid-aligned flag.
//    - sub_in=1: computes a_in + ~b_in + 1; c_in is ignored.
//      c_out=1 means no borrow (a_in >= b_in, unsigned).
//    - sub_in=0: plain add.
//  CLA_PIPE_SUB_EN undefined: sub_in port absent; the block is add only.
// TESTING (WIDTH=64, SEG=16, latency 4)
//  1. a=0xFFFF_FFFF_FFFF_FFFF, b=1, c_in=0
//     -> 4 cycles later: sum=0, c_out=1, out_valid high for exactly 1 cycle.
//  2. Back-to-back ops 1+2, c_in=1 on 5+5, 0x0000_FFFF_0000_0000+0x0000_0001_0000_0000
//     -> sums 3, 0xB, 0x0001_0000_0000_0000 on 3 consecutive cycles, c_out=0.
//  3. Op 0x1234+0x1 accepted, then en=0 for 3 cycles mid-flight
//     -> out_valid appears 7 cycles after accept, sum=0x1235, no duplicate.
//  4. Op 0xFFFF+1 accepted, then flush=1 together with in_valid op 2+2
//     -> out_valid stays 0 for the next 6 cycles.
//  5. rst asserted asynchronously 2 cycles after accept
//     -> sum_out=0, c_out=0, out_valid=0 before the next edge. After release, no stale output.
//  6. CLA_PIPE_SUB_EN: sub_in=1 with 5-7 -> sum=0xFFFF_FFFF_FFFF_FFFE, c_out=0.
//     sub_in=1 with 7-5 -> sum=2, c_out=1.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Segment-pipelined carry-lookahead adder: one SEG-bit segment per stage, carry registered between stages.
// Optional subtract mode is compiled in with `define CLA_PIPE_SUB_EN (adds the sub_in port).
module cla_pipe_adder #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
`ifdef CLA_PIPE_SUB_EN
    input  logic             sub_in,
`endif
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             out_valid
);

    localparam int NSEG = WIDTH / SEG;
    localparam int NGRP = SEG / 4;

    // Groups of 4 bits use full lookahead; the group carry ripples to the next group.
    function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           ci);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG-1:0] c;
        logic           cg;
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        cg = ci;
        for (int k = 0; k < NGRP; k++) begin
            c[4*k]   = cg;
            c[4*k+1] = g[4*k] | (p[4*k] & cg);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & cg);
            cg       = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & cg);
        end
        return {cg, p ^ c};
    endfunction

    logic sub;
`ifdef CLA_PIPE_SUB_EN
    assign sub = sub_in;
`else
    assign sub = 1'b0;
`endif

    for (genvar s = 0; s < NSEG; s++) begin : stg
        localparam int REM = WIDTH - (s + 1) * SEG;

        logic [WIDTH-s*SEG-1:0] a_up;
        logic [WIDTH-s*SEG-1:0] b_up;
        logic                   cin;
        logic                   vin;
        logic                   sub_s;
        logic [SEG:0]           res;
        logic [(s+1)*SEG-1:0]   sum_r;
        logic                   carry_r;
        logic                   valid_r;

        if (s == 0) begin : head
            assign a_up  = a_in;
            assign b_up  = b_in;
            assign cin   = sub ? 1'b1 : c_in;
            assign vin   = in_valid;
            assign sub_s = sub;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    sum_r <= '0;
                else if (en)
                    sum_r <= res[SEG-1:0];
            end
        end else begin : body
            assign a_up  = stg[s-1].ops.a_r;
            assign b_up  = stg[s-1].ops.b_r;
            assign cin   = stg[s-1].carry_r;
            assign vin   = stg[s-1].valid_r;
            assign sub_s = stg[s-1].ops.sub_r;

            // Lower sum segments travel with the op so the output is aligned.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    sum_r <= '0;
                else if (en)
                    sum_r <= {res[SEG-1:0], stg[s-1].sum_r};
            end
        end

        assign res = cla_seg(a_up[SEG-1:0], b_up[SEG-1:0] ^ {SEG{sub_s}}, cin);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                carry_r <= 1'b0;
                valid_r <= 1'b0;
            end else begin
                if (en) begin
                    carry_r <= res[SEG];
                    valid_r <= vin;
                end
                if (flush)
                    valid_r <= 1'b0;
            end
        end

        // Operand bits not yet consumed by a segment, plus the op's subtract flag.
        if (s < NSEG - 1) begin : ops
            logic [REM-1:0] a_r;
            logic [REM-1:0] b_r;
            logic           sub_r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_r   <= '0;
                    b_r   <= '0;
                    sub_r <= 1'b0;
                end else if (en) begin
                    a_r   <= a_up[WIDTH-s*SEG-1:SEG];
                    b_r   <= b_up[WIDTH-s*SEG-1:SEG];
                    sub_r <= sub_s;
                end
            end
        end
    end

    assign sum_out   = stg[NSEG-1].sum_r;
    assign c_out     = stg[NSEG-1].carry_r;
    assign out_valid = stg[NSEG-1].valid_r;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (WIDTH=64, SEG=16): directed cases plus randomized traffic.
module tb_cla_pipe_adder;

    localparam int WIDTH = 64;
    localparam int SEG   = 16;
    localparam int NSEG  = WIDTH / SEG;
`ifdef CLA_PIPE_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             sub_in;
    logic [WIDTH-1:0] sum_out;
    logic             c_out;
    logic             out_valid;

    cla_pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
`ifdef CLA_PIPE_SUB_EN
        .sub_in    (sub_in),
`endif
        .sum_out   (sum_out),
        .c_out     (c_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             co;
        int               tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;
    bit   last_adv = 1'b0;

    // Reference: plain wide arithmetic; subtraction as a + ~b + 1.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic ci, input logic sb);
        if (sb)
            return {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(ci);
    endfunction

    task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue side: every accepted op pushes its expected result; flush/reset drop everything in flight.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            last_adv = 1'b0;
        end else begin
            if (flush)
                exp_q.delete();
            if (en)
                edge_cnt++;
            if (en && in_valid && !flush) begin
                logic [WIDTH:0] r;
                r = model(a_in, b_in, c_in, HAS_SUB ? sub_in : 1'b0);
                exp_q.push_back('{sum: r[WIDTH-1:0], co: r[WIDTH], tag: edge_cnt});
            end
            last_adv = en;
        end
    end

    // Output side: a result is new only when the pipeline advanced on the preceding edge.
    always @(negedge clk) begin
        if (!rst && last_adv && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out: got out_valid=1 sum=%h required no output at %0t", sum_out, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", {1'b0, sum_out}, {1'b0, e.sum});
                check("c_out", (WIDTH+1)'(c_out), (WIDTH+1)'(e.co));
                check("latency_en_edges", (WIDTH+1)'(edge_cnt - e.tag), (WIDTH+1)'(NSEG - 1));
            end
        end
    end

    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic ci, input logic sb, input logic e, input logic f);
        in_valid = v;
        a_in     = a;
        b_in     = b;
        c_in     = ci;
        sub_in   = sb;
        en       = e;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic e);
        for (int i = 0; i < n; i++)
            drive(1'b0, '0, '0, 1'b0, 1'b0, e, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0;
        a_in = '0; b_in = '0; c_in = 1'b0; sub_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_sum", {1'b0, sum_out}, '0);
        check("reset_c_out", (WIDTH+1)'(c_out), '0);
        check("reset_out_valid", (WIDTH+1)'(out_valid), '0);

        // Full-width carry propagation
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(6, 1'b1);

        // Back-to-back ops
        drive(1'b1, 64'd1, 64'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 64'd5, 64'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 64'h0000_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(6, 1'b1);

        // Stall mid-flight
        drive(1'b1, 64'h1234, 64'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);
        idle(3, 1'b0);
        idle(6, 1'b1);

        // Flush drops in-flight op and the op offered alongside it
        drive(1'b1, 64'hFFFF, 64'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 64'd2, 64'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            idle(1, 1'b1);
            check("flush_no_output", (WIDTH+1)'(out_valid), '0);
        end

        // Asynchronous reset mid-operation
        drive(1'b1, 64'hDEAD_BEEF_0000_FFFF, 64'h1111_2222_3333_0001, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sum", {1'b0, sum_out}, '0);
        check("async_rst_c_out", (WIDTH+1)'(c_out), '0);
        check("async_rst_out_valid", (WIDTH+1)'(out_valid), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6, 1'b1);

`ifdef CLA_PIPE_SUB_EN
        drive(1'b1, 64'd5, 64'd7, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 64'd7, 64'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 64'd9, 64'd9, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(6, 1'b1);
`endif

        // Randomized traffic with stalls, occasional flushes and carry-heavy operands
        for (int i = 0; i < 400; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = ~a;
                1: a = '1;
                2: b = a;
                default: ;
            endcase
            drive(($urandom_range(0, 3) != 0), a, b, $urandom_range(0, 1) == 1,
                  HAS_SUB ? ($urandom_range(0, 1) == 1) : 1'b0,
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 31) == 0));
        end
        idle(NSEG + 4, 1'b1);

        check("scoreboard_drained", (WIDTH+1)'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
